// File: rtl/shift_pkg.sv
// Shared types and sizing for the multi-cycle shift sequencer.
//   Bus_size    : operand/result width
//   Shamt_w     : shift-amount width
//   shift_op_t  : shift operation encoding (OP_RSVD executes as SLL)
//   seq_state_t : sequencer FSM states
package shift_pkg;

   localparam int unsigned Bus_size = 32;
   localparam int unsigned Shamt_w  = $clog2(Bus_size);

   typedef enum logic [1:0] {
      OP_SLL  = 2'b00,
      OP_SRL  = 2'b01,
      OP_SRA  = 2'b10,
      OP_RSVD = 2'b11
   } shift_op_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } seq_state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the execute stage and the shift sequencer.
//   start, op, shamt, operand : request, driven by the master (execute stage)
//   busy, done, result        : status/response, driven by the slave (sequencer)
interface shift_sequencer_if;
   import shift_pkg::*;

   logic                 start;
   shift_op_t            op;
   logic [Shamt_w-1:0]   shamt;
   logic [Bus_size-1:0]  operand;
   logic                 busy;
   logic                 done;
   logic [Bus_size-1:0]  result;

   modport master (
      output start, op, shamt, operand,
      input  busy, done, result
   );

   modport slave (
      input  start, op, shamt, operand,
      output busy, done, result
   );

endinterface

// File: rtl/shift_step.sv
// Combinational single-position shift used once per sequencer cycle.
//   shift_in  : value to shift
//   op        : SLL / SRL / SRA (reserved encoding behaves as SLL)
//   shift_out : value shifted by exactly one bit position
module shift_step
   import shift_pkg::*;
#(
   parameter int unsigned Bus_size = shift_pkg::Bus_size
) (
   input  logic [Bus_size-1:0] shift_in,
   input  shift_op_t           op,
   output logic [Bus_size-1:0] shift_out
);

   // One-bit shift; left shift is the default so OP_RSVD falls through to SLL
   always_comb begin
      shift_out = {shift_in[Bus_size-2:0], 1'b0};
      case (op)
         OP_SRL:  shift_out = {1'b0, shift_in[Bus_size-1:1]};
         OP_SRA:  shift_out = {shift_in[Bus_size-1], shift_in[Bus_size-1:1]};
         default: shift_out = {shift_in[Bus_size-2:0], 1'b0};
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA controller: shifts a registered operand one bit per
// clock until the requested amount is consumed, then pulses done.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : slave side of shift_sequencer_if
//            start/op/shamt/operand sampled only on the accepting edge in IDLE
//            busy   = state != IDLE
//            done   = one-cycle pulse in the DONE state
//            result = accumulator, held until the next accepted start
module shift_sequencer
   import shift_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   shift_sequencer_if.slave   bus
);

   seq_state_t          state_q, state_d;
   logic [Bus_size-1:0] acc_q,   acc_d;
   logic [Shamt_w-1:0]  cnt_q,   cnt_d;
   shift_op_t           op_q,    op_d;
   logic [Bus_size-1:0] step_out;

   // Single-step shifter fed from the registered accumulator and operation
   shift_step #(
      .Bus_size (Bus_size)
   ) u_step (
      .shift_in  (acc_q),
      .op        (op_q),
      .shift_out (step_out)
   );

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         op_q    <= OP_SLL;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   // Next-state and datapath update; registers hold unless explicitly changed
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      op_d    = op_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               acc_d   = bus.operand;
               op_d    = bus.op;
               cnt_d   = bus.shamt;
               // A zero shift amount skips SHIFT and reports the operand as-is
               state_d = (bus.shamt != '0) ? S_SHIFT : S_DONE;
            end
         end
         S_SHIFT: begin
            acc_d = step_out;
            cnt_d = cnt_q - Shamt_w'(1);
            // Exit on the last step so cnt never wraps below zero
            if (cnt_q == Shamt_w'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded purely from registered state
   assign bus.busy   = (state_q != S_IDLE);
   assign bus.done   = (state_q == S_DONE);
   assign bus.result = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios followed by
// random back-to-back operations compared against a shift-operator model.
module tb_shift_sequencer;
   import shift_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   shift_sequencer_if bus ();

   shift_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: whole shift in one step using the language shift operators
   function automatic logic [31:0] ref_shift(input logic [1:0] op, input int sh,
                                             input logic [31:0] v);
      case (op)
         2'd1:    return v >> sh;
         2'd2:    return 32'($signed(v) >>> sh);
         default: return v << sh;
      endcase
   endfunction

   // Advance one clock and settle just past the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request from IDLE and check latency, busy, done and result.
   // Returns in the first cycle with busy low, ready for a back-to-back start.
   task automatic run_op(input logic [1:0] op, input int sh, input logic [31:0] v,
                         input string tag);
      logic [31:0] exp;
      exp = ref_shift(op, sh, v);
      bus.start   = 1'b1;
      bus.op      = shift_op_t'(op);
      bus.shamt   = 5'(sh);
      bus.operand = v;
      tick();
      bus.start   = 1'b0;
      bus.op      = shift_op_t'($urandom_range(0, 3));
      bus.shamt   = 5'($urandom_range(0, 31));
      bus.operand = $urandom();
      for (int c = 1; c <= sh + 1; c++) begin
         chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
         chk({tag, "_done"}, 32'(bus.done), 32'(c == sh + 1));
         if (c == sh + 1) chk({tag, "_result"}, bus.result, exp);
         else tick();
      end
      tick();
      chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done_after"}, 32'(bus.done), 32'd0);
      chk({tag, "_result_hold"}, bus.result, exp);
   endtask

   initial begin
      bus.start   = 1'b0;
      bus.op      = OP_SLL;
      bus.shamt   = '0;
      bus.operand = '0;
      rst_n       = 1'b0;
      tick();
      tick();
      chk("reset_busy",   32'(bus.busy), 32'd0);
      chk("reset_done",   32'(bus.done), 32'd0);
      chk("reset_result", bus.result,    32'd0);
      rst_n = 1'b1;
      tick();

      // Directed operations, issued back-to-back
      run_op(2'd0, 3,  32'h0000_000A, "sll_a_3");
      run_op(2'd2, 31, 32'h8000_0000, "sra_31");
      run_op(2'd1, 31, 32'h8000_0000, "srl_31");
      run_op(2'd1, 0,  32'h0000_0066, "srl_0");
      run_op(2'd3, 4,  32'h0000_0001, "rsvd_4");

      // Start pulses during SHIFT and DONE are ignored; operand changes ignored
      bus.start   = 1'b1;
      bus.op      = OP_SLL;
      bus.shamt   = 5'd5;
      bus.operand = 32'h0000_0001;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         chk("coll_busy", 32'(bus.busy), 32'd1);
         chk("coll_done", 32'(bus.done), 32'(c == 6));
         if (c == 2 || c == 6) begin
            bus.start   = 1'b1;
            bus.op      = OP_SRL;
            bus.shamt   = 5'd1;
            bus.operand = 32'hFFFF_FFFF;
         end else begin
            bus.start = 1'b0;
         end
         if (c == 3) bus.operand = 32'hDEAD_BEEF;
         tick();
      end
      bus.start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk("coll_idle_busy", 32'(bus.busy), 32'd0);
         chk("coll_idle_done", 32'(bus.done), 32'd0);
         chk("coll_result",    bus.result,    32'h0000_0020);
         tick();
      end

      // Reset in the middle of a long shift discards the operation
      bus.start   = 1'b1;
      bus.op      = OP_SLL;
      bus.shamt   = 5'd20;
      bus.operand = 32'h0000_000A;
      tick();
      bus.start = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst_mid_busy",   32'(bus.busy), 32'd0);
      chk("rst_mid_done",   32'(bus.done), 32'd0);
      chk("rst_mid_result", bus.result,    32'd0);
      for (int c = 0; c < 25; c++) begin
         chk("rst_no_done", 32'(bus.done), 32'd0);
         tick();
      end
      run_op(2'd1, 8, 32'h0000_0100, "post_rst_srl");

      // Start held high: accepted once per IDLE cycle, period shamt+2
      bus.start   = 1'b1;
      bus.op      = OP_SLL;
      bus.shamt   = 5'd2;
      bus.operand = 32'h0000_0003;
      for (int c = 1; c <= 12; c++) begin
         tick();
         chk("held_done", 32'(bus.done), 32'((c % 4) == 3));
         chk("held_busy", 32'(bus.busy), 32'((c % 4) != 0));
      end
      bus.start = 1'b0;
      chk("held_result", bus.result, 32'h0000_000C);
      for (int c = 0; c < 4; c++) tick();
      chk("held_drain_busy", 32'(bus.busy), 32'd0);

      // Random operations with occasional idle gaps
      for (int n = 0; n < 40; n++) begin
         logic [1:0]  rop;
         int          rsh;
         logic [31:0] rv;
         int          gap;
         rop = 2'($urandom_range(0, 3));
         rsh = int'($urandom_range(0, 31));
         rv  = $urandom();
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) tick();
         run_op(rop, rsh, rv, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
